parse_stream: RTL and testbench

//  Streaming, parametrised successor of the batch Kyber Parse sampler. Consumes an XOF byte stream
//  (valid/ready), forms two 12-bit candidates per 3-byte group, rejects values >= Q, emits accepted

---
 rtl/kyber_pkg.sv | 28 ++
 rtl/parse_cand_unit.sv | 33 +++
 rtl/parse_stream.sv | 216 +++++++++++++++++++++
 tb/tb_parse_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
//   Shared constants and types for the Kyber rejection-sampling (Parse) stream.
//   KYBER_Q        modulus; a 12-bit candidate is kept iff it is below this value
//   KYBER_N        coefficients per polynomial
//   KYBER_K_MAX    maximum polynomials generated per start (one A-matrix row)
//   KYBER_COEFF_W  candidate/coefficient width
//   coeff_t        one 12-bit candidate or coefficient
//   parse_state_t  sampler FSM states
// -----------------------------------------------------------------------------
package kyber_pkg;

  localparam int KYBER_Q       = 3329;
  localparam int KYBER_N       = 256;
  localparam int KYBER_K_MAX   = 4;
  localparam int KYBER_COEFF_W = 12;

  typedef logic [KYBER_COEFF_W-1:0] coeff_t;

  // COLLECT gathers one 3-byte group; EMIT0/EMIT1 offer its two candidates.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT0   = 2'd2,
    ST_EMIT1   = 2'd3
  } parse_state_t;

endpackage

// File: rtl/parse_cand_unit.sv
// -----------------------------------------------------------------------------
// parse_cand_unit
//   Purely combinational split of one 3-byte XOF group into two 12-bit
//   candidates and their accept flags.
//   Ports:
//     b0_i, b1_i, b2_i  in   8   bytes of the group, in arrival order
//     d1_o              out  12  b0 + 256*(b1 & 0xF)
//     d2_o              out  12  (b1 >> 4) + 16*b2
//     acc1_o, acc2_o    out  1   candidate is below the modulus Q
// -----------------------------------------------------------------------------
module parse_cand_unit
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic [7:0] b0_i,
  input  logic [7:0] b1_i,
  input  logic [7:0] b2_i,
  output coeff_t     d1_o,
  output coeff_t     d2_o,
  output logic       acc1_o,
  output logic       acc2_o
);

  localparam coeff_t Q_C = coeff_t'(Q);

  // Both candidates are plain bit concatenations, so they can never overflow.
  assign d1_o   = {b1_i[3:0], b0_i};
  assign d2_o   = {b2_i, b1_i[7:4]};
  assign acc1_o = (d1_o < Q_C);
  assign acc2_o = (d2_o < Q_C);

endmodule

// File: rtl/parse_stream.sv
// -----------------------------------------------------------------------------
// parse_stream
//   Streaming Kyber Parse sampler. Pulls XOF bytes on a valid/ready input,
//   forms two 12-bit candidates per 3-byte group, drops candidates >= Q and
//   streams accepted coefficients out. One start produces num_poly polynomials
//   of N coefficients back-to-back.
//
//   Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid and ready are both high; once out_valid is raised, out_coeff,
//   out_idx, out_poly and out_last hold steady until that transfer occurs.
//   in_ready is only ever high in COLLECT, so no byte is fetched ahead of use.
//
//   Ports:
//     clk, rst    in        clock, synchronous active-high reset
//     start       in   1    begin a job (sampled only while idle)
//     num_poly    in   KP_W polys for this job, latched at start (0 -> 1)
//     in_valid    in   1    XOF byte valid
//     in_ready    out  1    sampler will take a byte
//     in_data     in   8    XOF byte
//     out_valid   out  1    coefficient valid
//     out_ready   in   1    sink takes the coefficient
//     out_coeff   out  COEFF_W accepted coefficient (< Q)
//     out_idx     out  IDX_W   coefficient index within its polynomial
//     out_poly    out  KP_W    polynomial index within the job
//     out_last    out  1    final coefficient of the final polynomial
//     busy        out  1    job in progress
//     done        out  1    one-cycle pulse after the final coefficient
//     rej_cnt     out  16   rejected candidates since start
//
//   Build option: define PARSE_STATS_EN to include the saturating reject
//   counter; without it rej_cnt is tied to zero and nothing else changes.
// -----------------------------------------------------------------------------
module parse_stream
  import kyber_pkg::*;
#(
  parameter int Q       = KYBER_Q,
  parameter int N       = KYBER_N,
  parameter int K_MAX   = KYBER_K_MAX,
  parameter int COEFF_W = KYBER_COEFF_W,
  parameter int IDX_W   = $clog2(N),
  parameter int KP_W    = $clog2(K_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KP_W-1:0]    num_poly,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_coeff,
  output logic [IDX_W-1:0]   out_idx,
  output logic [KP_W-1:0]    out_poly,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [15:0]        rej_cnt
);

  parse_state_t      state_q, state_d;
  logic [1:0]        byte_sel_q, byte_sel_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [KP_W-1:0]   poly_q, poly_d;
  logic [KP_W-1:0]   np_q, np_d;
  logic              done_q, done_d;
  logic              rej_inc, rej_clr;

  coeff_t            d1, d2, cur_coeff;
  logic              acc1, acc2;
  logic              emit_acc, last_idx, last_poly;
  parse_state_t      after_emit;

  parse_cand_unit #(.Q(Q)) u_cand (
    .b0_i   (b0_q),
    .b1_i   (b1_q),
    .b2_i   (b2_q),
    .d1_o   (d1),
    .d2_o   (d2),
    .acc1_o (acc1),
    .acc2_o (acc2)
  );

  // Outputs come straight from the held group registers and counters, so
  // they are stable for as long as the FSM waits in an EMIT state.
  assign emit_acc  = ((state_q == ST_EMIT0) && acc1) || ((state_q == ST_EMIT1) && acc2);
  assign cur_coeff = (state_q == ST_EMIT1) ? d2 : d1;
  assign last_idx  = (idx_q == IDX_W'(N - 1));
  assign last_poly = (poly_q == (np_q - KP_W'(1)));
  assign after_emit = (state_q == ST_EMIT0) ? ST_EMIT1 : ST_COLLECT;

  assign in_ready  = (state_q == ST_COLLECT);
  assign out_valid = emit_acc;
  assign out_coeff = emit_acc ? COEFF_W'(cur_coeff) : '0;
  assign out_idx   = idx_q;
  assign out_poly  = poly_q;
  assign out_last  = emit_acc && last_idx && last_poly;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    idx_d      = idx_q;
    poly_d     = poly_q;
    np_d       = np_q;
    done_d     = 1'b0;
    rej_inc    = 1'b0;
    rej_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_COLLECT;
          byte_sel_d = 2'd0;
          idx_d      = '0;
          poly_d     = '0;
          rej_clr    = 1'b1;
          if (num_poly == '0)                    np_d = KP_W'(1);
          else if (num_poly > KP_W'(K_MAX))      np_d = KP_W'(K_MAX);
          else                                   np_d = num_poly;
        end
      end

      ST_COLLECT: begin
        if (in_valid) begin
          case (byte_sel_q)
            2'd0:    begin b0_d = in_data; byte_sel_d = 2'd1; end
            2'd1:    begin b1_d = in_data; byte_sel_d = 2'd2; end
            default: begin
              b2_d       = in_data;
              byte_sel_d = 2'd0;
              state_d    = ST_EMIT0;
            end
          endcase
        end
      end

      ST_EMIT0, ST_EMIT1: begin
        if (!emit_acc) begin
          // Rejected candidate costs exactly one cycle.
          rej_inc = 1'b1;
          state_d = after_emit;
        end else if (out_ready) begin
          if (last_idx) begin
            idx_d = '0;
            if (last_poly) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              // A new polynomial always starts on a fresh group; any
              // pending d2 of the current group is dropped uncounted.
              poly_d  = poly_q + KP_W'(1);
              state_d = ST_COLLECT;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = after_emit;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_sel_q <= 2'd0;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      idx_q      <= '0;
      poly_q     <= '0;
      np_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      idx_q      <= idx_d;
      poly_q     <= poly_d;
      np_q       <= np_d;
      done_q     <= done_d;
    end
  end

`ifdef PARSE_STATS_EN
  logic [15:0] rej_q, rej_d;

  always_comb begin
    rej_d = rej_q;
    if (rej_clr)                         rej_d = '0;
    else if (rej_inc && (rej_q != 16'hFFFF)) rej_d = rej_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rej_q <= '0;
    else     rej_q <= rej_d;
  end

  assign rej_cnt = rej_q;
`else
  logic unused_stats;
  assign unused_stats = rej_inc ^ rej_clr;
  assign rej_cnt      = '0;
`endif

endmodule

// File: tb/tb_parse_stream.sv
module tb_parse_stream;

  localparam int Q       = 3329;
  localparam int N       = 256;
  localparam int K_MAX   = 4;
  localparam int COEFF_W = 12;
  localparam int IDX_W   = 8;
  localparam int KP_W    = 3;
  localparam int BUDGET  = 20000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start;
  logic [KP_W-1:0]    num_poly;
  logic               in_valid, in_ready;
  logic [7:0]         in_data;
  logic               out_valid, out_ready;
  logic [COEFF_W-1:0] out_coeff;
  logic [IDX_W-1:0]   out_idx;
  logic [KP_W-1:0]    out_poly;
  logic               out_last, busy, done;
  logic [15:0]        rej_cnt;

  parse_stream #(
    .Q(Q), .N(N), .K_MAX(K_MAX), .COEFF_W(COEFF_W), .IDX_W(IDX_W), .KP_W(KP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_poly(num_poly),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
    .out_idx(out_idx), .out_poly(out_poly), .out_last(out_last),
    .busy(busy), .done(done), .rej_cnt(rej_cnt)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [7:0]  src[$];
  logic [23:0] exp_q[$];
  int exp_bytes, exp_rej;
  int obs_coeff[$];
  int obs_idx[$];
  int bytes_used, first_hs_bytes, beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int stats_rej(input int r);
`ifdef PARSE_STATS_EN
    return (r > 65535) ? 65535 : r;
`else
    return 0 * r;
`endif
  endfunction

  // stimulus helpers
  task automatic add_bytes(input int n, input bit zero);
    for (int i = 0; i < n; i++) src.push_back(zero ? 8'h00 : 8'($urandom));
  endtask

  // Reference: walk the byte list group by group, keep candidates below Q,
  // close a polynomial after N keeps (the rest of that group is dropped).
  task automatic build_model(input int np);
    int p = 0, k = 0, pos = 0, d1, d2, d;
    exp_q.delete();
    exp_rej = 0;
    while (p < np && pos + 2 < src.size()) begin
      d1 = int'(src[pos]) + 256 * int'(src[pos+1] & 8'h0F);
      d2 = int'(src[pos+1] >> 4) + 16 * int'(src[pos+2]);
      pos += 3;
      for (int j = 0; j < 2; j++) begin
        d = (j == 0) ? d1 : d2;
        if (d < Q) begin
          exp_q.push_back({p[2:0], k[7:0], d[11:0], (k == N - 1 && p == np - 1)});
          k++;
          if (k == N) begin
            k = 0;
            p++;
            break;
          end
        end else begin
          exp_rej++;
        end
      end
    end
    exp_bytes = pos;
  endtask

  // driver + monitor for one job; abort_after >= 0 resets after that many beats
  task automatic run_job(input int np, input int ready_pct, input int valid_pct,
                         input int stall_first, input int abort_after);
    int np_eff, cyc = 0, stall_cnt = 0;
    bit got_done = 0, done_exp = 0, prev_hold = 0, aborted = 0;
    logic [22:0] prev_out;
    logic [23:0] e;
    np_eff = (np == 0) ? 1 : ((np > K_MAX) ? K_MAX : np);
    build_model(np_eff);
    obs_coeff.delete();
    obs_idx.delete();
    bytes_used = 0;
    first_hs_bytes = -1;
    beats = 0;

    @(negedge clk);
    start = 1'b1; num_poly = KP_W'(np); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; num_poly = KP_W'($urandom_range(0, 7));
    chk("busy_after_start", busy, 1);
    chk("in_ready_collect", in_ready, 1);

    while (cyc < BUDGET) begin
      if (prev_hold) begin
        chk("hold_stable", {out_valid, out_coeff, out_idx, out_poly}, {1'b1, prev_out[22:0]});
        chk("hold_in_ready", in_ready, 0);
      end
      chk("done_pulse", done, done_exp);
      if (done_exp) begin
        chk("busy_at_done", busy, 0);
        got_done = 1;
        break;
      end

      in_valid = ($urandom_range(0, 99) < valid_pct) && (bytes_used < src.size());
      in_data  = in_valid ? src[bytes_used] : 8'($urandom);
      if (out_valid === 1'b1 && stall_cnt < stall_first) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;

      if (in_valid && in_ready) bytes_used++;
      if (out_valid && out_ready) begin
        if (first_hs_bytes < 0) first_hs_bytes = bytes_used;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_poly, out_idx, out_coeff, out_last}, e);
        end
        obs_coeff.push_back(int'(out_coeff));
        obs_idx.push_back(int'(out_idx));
        beats++;
        done_exp = (exp_q.size() == 0);
        if (abort_after >= 0 && beats == abort_after) begin
          aborted = 1;
          break;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_coeff, out_idx, out_poly};
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    if (aborted) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_idx", out_idx, 0);
      chk("abort_poly", out_poly, 0);
      chk("abort_rej", rej_cnt, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_no_done", done, 0);
      end
    end else begin
      chk("job_finished", got_done, 1);
      chk("bytes_consumed", bytes_used, exp_bytes);
      chk("rej_cnt", rej_cnt, stats_rej(exp_rej));
      chk("beats_left", exp_q.size(), 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_in_ready", in_ready, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_poly = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coeff", out_coeff, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_poly", out_poly, 0);
    chk("rst_rej", rej_cnt, 0);
    rst = 1'b0;

    // 01 02 03 -> 513, 48
    src.delete();
    src.push_back(8'h01); src.push_back(8'h02); src.push_back(8'h03);
    add_bytes(6 * N, 0);
    run_job(1, 100, 100, 0, -1);
    chk("t1_coeff0", obs_coeff[0], 513);
    chk("t1_coeff1", obs_coeff[1], 48);
    chk("t1_idx0", obs_idx[0], 0);
    chk("t1_idx1", obs_idx[1], 1);

    // d1 = 3328 accepted, d1 = 3329 rejected
    src.delete();
    src.push_back(8'h00); src.push_back(8'h0D); src.push_back(8'h00);
    src.push_back(8'h01); src.push_back(8'h0D); src.push_back(8'h00);
    add_bytes(6 * N, 0);
    run_job(1, 70, 80, 0, -1);
    chk("t2_coeff0", obs_coeff[0], 3328);
    chk("t2_coeff1", obs_coeff[1], 0);
    chk("t2_coeff2", obs_coeff[2], 0);
    chk("t2_idx2", obs_idx[2], 2);

    // two all-rejected FF groups, then zeros
    src.delete();
    for (int i = 0; i < 6; i++) src.push_back(8'hFF);
    add_bytes(6 * N, 1);
    run_job(1, 100, 100, 0, -1);
    chk("t3_first_beat_bytes", first_hs_bytes, 9);
    chk("t3_coeff0", obs_coeff[0], 0);
    chk("t3_coeff1", obs_coeff[1], 0);
    chk("t3_rej", rej_cnt, stats_rej(4));

    // two polys of zeros, random sink readiness
    src.delete();
    add_bytes(6 * N, 1);
    run_job(2, 50, 100, 0, -1);
    chk("t4_beats", beats, 512);
    chk("t4_bytes", bytes_used, 768);
    chk("t4_idx255", obs_idx[255], 255);
    chk("t4_idx_wrap", obs_idx[256], 0);

    // odd keep count forces the d2 drop at the polynomial boundary
    src.delete();
    src.push_back(8'hFF); src.push_back(8'h0F); src.push_back(8'h00);
    add_bytes(6 * N, 1);
    run_job(2, 60, 90, 0, -1);
    chk("t5_beats", beats, 512);
    chk("t5_bytes", bytes_used, 771);

    // sink stalls 5 cycles on the first coefficient
    src.delete();
    add_bytes(6 * N, 0);
    run_job(1, 60, 75, 5, -1);

    // abort mid-poly, then a fresh job (num_poly 0 behaves as 1)
    src.delete();
    add_bytes(6 * 3 * N, 0);
    run_job(3, 80, 80, 0, 100);
    src.delete();
    add_bytes(6 * N, 0);
    run_job(0, 80, 80, 0, -1);
    chk("t8_idx0", obs_idx[0], 0);
    chk("t8_beats", beats, 256);

    // full row, random everything
    src.delete();
    add_bytes(6 * 4 * N, 0);
    run_job(4, 80, 70, 0, -1);
    chk("t9_beats", beats, 1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
